// File: rtl/seq_divider_if.sv
// Request/response handshake bundle for seq_divider.
// The slave modport is the divider side; master is the requester side.

interface seq_divider_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder
    );

    modport master (
        output i_valid, i_dividend, i_divisor, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned 32-bit restoring divider retiring BITS_PER_CYCLE quotient bits per clock.
// Each trial subtraction is rem + ~divisor + 1 through its own 32-bit carry-lookahead adder.

module seq_divider_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  blk_g;
    logic [7:0]  blk_p;
    logic [8:0]  blk_c;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit lookahead groups; group carries chain through group generate/propagate.
    // NOTE: every variable written in this block gets a value first, so no latch is inferred.
    always_comb begin
        blk_g = '0;
        blk_p = '0;
        blk_c = '0;
        c     = '0;
        for (int k = 0; k < 8; k++) begin
            blk_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            blk_p[k] = &p[4*k +: 4];
        end
        blk_c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = blk_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & blk_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & blk_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & blk_c[k]);
        end
        c[32] = blk_c[8];
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

module seq_divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int N_STEPS = 32 / BITS_PER_CYCLE;
    localparam int CNT_W   = $clog2(N_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STEPS - 1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
        $error("seq_divider: BITS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        divisor_q, divisor_d;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        quo_q, quo_d;
    logic [31:0]        res_quo_q, res_quo_d;
    logic [31:0]        res_rem_q, res_rem_d;
    logic [31:0]        rem_step;
    logic [31:0]        quo_step;
    logic               ready;
    logic               valid;

    // Cascade of restoring steps; quo shifts out dividend bits on top, quotient bits in at the bottom.
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        logic [31:0] rem_in;
        logic [31:0] quo_in;
        logic [31:0] trial;
        logic [31:0] diff;
        logic [31:0] rem_out;
        logic [31:0] quo_out;
        logic        carry;
        logic        ge;

        if (k == 0) begin : g_head
            assign rem_in = rem_q;
            assign quo_in = quo_q;
        end else begin : g_link
            assign rem_in = g_step[k-1].rem_out;
            assign quo_in = g_step[k-1].quo_out;
        end

        assign trial = {rem_in[30:0], quo_in[31]};

        seq_divider_cla u_cla (
            .a    (trial),
            .b    (~divisor_q),
            .cin  (1'b1),
            .sum  (diff),
            .cout (carry)
        );

        // rem_in[31] is bit 32 of the shifted remainder: when set, t >= divisor whatever the borrow.
        assign ge      = rem_in[31] | carry;
        assign rem_out = ge ? diff : trial;
        assign quo_out = {quo_in[30:0], ge};
    end

    assign rem_step = g_step[BITS_PER_CYCLE-1].rem_out;
    assign quo_step = g_step[BITS_PER_CYCLE-1].quo_out;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        ready     = 1'b0;
        valid     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.i_valid) begin
                    divisor_d = bus.i_divisor;
                    rem_d     = '0;
                    quo_d     = bus.i_dividend;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    res_quo_d = quo_step;
                    res_rem_d = rem_step;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                valid = 1'b1;
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_quo_q <= '0;
            res_rem_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid;
    assign bus.o_quotient  = res_quo_q;
    assign bus.o_remainder = res_rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: BITS_PER_CYCLE=1 and =4 instances against a
// cycle-level arithmetic model, with directed literal cases and randomized traffic.

module tb_seq_divider;
    logic clk;
    logic rst;

    logic        req_valid    [2];
    logic [31:0] req_dividend [2];
    logic [31:0] req_divisor  [2];
    logic        rsp_ready    [2];

    logic        obs_ready [2];
    logic        obs_valid [2];
    logic [31:0] obs_quo   [2];
    logic [31:0] obs_rem   [2];

    seq_divider_if bus0 ();
    seq_divider_if bus1 ();

    assign bus0.i_valid    = req_valid[0];
    assign bus0.i_dividend = req_dividend[0];
    assign bus0.i_divisor  = req_divisor[0];
    assign bus0.i_ready    = rsp_ready[0];
    assign obs_ready[0]    = bus0.o_ready;
    assign obs_valid[0]    = bus0.o_valid;
    assign obs_quo[0]      = bus0.o_quotient;
    assign obs_rem[0]      = bus0.o_remainder;

    assign bus1.i_valid    = req_valid[1];
    assign bus1.i_dividend = req_dividend[1];
    assign bus1.i_divisor  = req_divisor[1];
    assign bus1.i_ready    = rsp_ready[1];
    assign obs_ready[1]    = bus1.o_ready;
    assign obs_valid[1]    = bus1.o_valid;
    assign obs_quo[1]      = bus1.o_quotient;
    assign obs_rem[1]      = bus1.o_remainder;

    seq_divider #(.BITS_PER_CYCLE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_divider #(.BITS_PER_CYCLE(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: an op is busy for N edges after acceptance, then its result
    // (plain / and %) is presented until the consumer takes it.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_e;
    mphase_e     m_phase [2];
    int          m_cnt   [2];
    logic [31:0] m_pq    [2];
    logic [31:0] m_pr    [2];
    logic [31:0] m_q     [2];
    logic [31:0] m_r     [2];

    function automatic int steps_of(input int l);
        return (l == 0) ? 32 : 8;
    endfunction

    initial begin
        for (int l = 0; l < 2; l++) begin
            m_phase[l] = M_IDLE;
            m_cnt[l]   = 0;
            m_q[l]     = '0;
            m_r[l]     = '0;
            m_pq[l]    = '0;
            m_pr[l]    = '0;
        end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int l = 0; l < 2; l++) begin
                if (rst) begin
                    m_phase[l] = M_IDLE;
                    m_q[l]     = '0;
                    m_r[l]     = '0;
                end else begin
                    case (m_phase[l])
                        M_IDLE: if (req_valid[l]) begin
                            m_phase[l] = M_BUSY;
                            m_cnt[l]   = 0;
                            if (req_divisor[l] == 0) begin
                                m_pq[l] = 32'hFFFF_FFFF;
                                m_pr[l] = req_dividend[l];
                            end else begin
                                m_pq[l] = req_dividend[l] / req_divisor[l];
                                m_pr[l] = req_dividend[l] % req_divisor[l];
                            end
                        end
                        M_BUSY: begin
                            m_cnt[l] = m_cnt[l] + 1;
                            if (m_cnt[l] == steps_of(l)) begin
                                m_phase[l] = M_DONE;
                                m_q[l]     = m_pq[l];
                                m_r[l]     = m_pr[l];
                            end
                        end
                        default: if (rsp_ready[l]) m_phase[l] = M_IDLE;
                    endcase
                end
            end
        end
    end

    // Compare process: outputs are checked mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int l = 0; l < 2; l++) begin
                    check($sformatf("lane%0d o_ready", l), {31'b0, obs_ready[l]}, 32'(m_phase[l] == M_IDLE));
                    check($sformatf("lane%0d o_valid", l), {31'b0, obs_valid[l]}, 32'(m_phase[l] == M_DONE));
                    check($sformatf("lane%0d o_quotient", l), obs_quo[l], m_q[l]);
                    check($sformatf("lane%0d o_remainder", l), obs_rem[l], m_r[l]);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Presents one request and holds it until accepted; returns the cycle of the accepting edge.
    task automatic send(input int l, input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
        int budget;
        budget = 0;
        @(negedge clk);
        req_valid[l]    = 1'b1;
        req_dividend[l] = a;
        req_divisor[l]  = b;
        while (!obs_ready[l] && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("lane%0d accept", l), {31'b0, obs_ready[l]}, 32'd1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        req_valid[l]    = 1'b0;
        req_dividend[l] = $urandom();
        req_divisor[l]  = $urandom();
    endtask

    task automatic run_op(input int l, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int hold);
        int acc;
        int lat;
        rsp_ready[l] = (hold == 0);
        send(l, a, b, acc);
        lat = 1;
        while (!obs_valid[l] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("lane%0d latency %0h/%0h", l, a, b), 32'(lat), (l == 0) ? 32'd33 : 32'd9);
        check($sformatf("lane%0d quotient %0h/%0h", l, a, b), obs_quo[l], eq);
        check($sformatf("lane%0d remainder %0h/%0h", l, a, b), obs_rem[l], er);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check($sformatf("lane%0d held o_valid", l), {31'b0, obs_valid[l]}, 32'd1);
                check($sformatf("lane%0d held o_ready", l), {31'b0, obs_ready[l]}, 32'd0);
                check($sformatf("lane%0d held quotient", l), obs_quo[l], eq);
                check($sformatf("lane%0d held remainder", l), obs_rem[l], er);
            end
            rsp_ready[l] = 1'b1;
        end
        @(negedge clk);
        check($sformatf("lane%0d idle after take", l), {31'b0, obs_ready[l]}, 32'd1);
        check($sformatf("lane%0d quotient kept in idle", l), obs_quo[l], eq);
    endtask

    task automatic rand_lane(input int l, input int n_ops);
        logic [31:0] a;
        logic [31:0] b;
        int          acc;
        for (int i = 0; i < n_ops; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                req_dividend[l] = $urandom();
                req_divisor[l]  = $urandom();
            end
            a = $urandom();
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'd1;
                2: begin
                    a = $urandom_range(0, 1000);
                    b = a + $urandom_range(1, 1000);
                end
                3: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                4: b = $urandom_range(1, 65535);
                default: b = $urandom();
            endcase
            send(l, a, b, acc);
        end
    endtask

    initial begin
        int  a0, a1, b0, b1;
        bit  done0, done1;

        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            req_valid[l]    = 1'b0;
            req_dividend[l] = '0;
            req_divisor[l]  = '0;
            rsp_ready[l]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        for (int l = 0; l < 2; l++) begin
            check($sformatf("lane%0d reset o_ready", l), {31'b0, obs_ready[l]}, 32'd1);
            check($sformatf("lane%0d reset o_valid", l), {31'b0, obs_valid[l]}, 32'd0);
            check($sformatf("lane%0d reset quotient", l), obs_quo[l], 32'd0);
            check($sformatf("lane%0d reset remainder", l), obs_rem[l], 32'd0);
        end

        fork
            run_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
            run_op(1, 32'd1000, 32'd33, 32'd30, 32'd10, 0);
        join
        fork
            run_op(0, 32'hDEADBEEF, 32'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 0);
            run_op(1, 32'hDEADBEEF, 32'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 0);
        join
        fork
            run_op(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);
            run_op(1, 32'd5, 32'd9, 32'd0, 32'd5, 0);
        join
        fork
            run_op(0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 5);
            run_op(1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 5);
        join

        // Reset in the 10th RUN cycle of lane 0, while lane 1 sits in DONE under backpressure.
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b0;
        fork
            send(0, 32'd200, 32'd3, a0);
            send(1, 32'd200, 32'd3, a1);
        join
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int l = 0; l < 2; l++) begin
            check($sformatf("lane%0d mid-op reset o_ready", l), {31'b0, obs_ready[l]}, 32'd1);
            check($sformatf("lane%0d mid-op reset o_valid", l), {31'b0, obs_valid[l]}, 32'd0);
            check($sformatf("lane%0d mid-op reset quotient", l), obs_quo[l], 32'd0);
            check($sformatf("lane%0d mid-op reset remainder", l), obs_rem[l], 32'd0);
        end
        fork
            run_op(0, 32'd50, 32'd5, 32'd10, 32'd0, 0);
            run_op(1, 32'd50, 32'd5, 32'd10, 32'd0, 0);
        join

        // Back-to-back requests with the result side always ready: one op every N+2 cycles.
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        fork
            begin
                send(0, 32'd12345, 32'd67, a0);
                send(0, 32'd99999, 32'd10, b0);
                check("lane0 accept spacing", 32'(b0 - a0), 32'd34);
            end
            begin
                send(1, 32'd12345, 32'd67, a1);
                send(1, 32'd99999, 32'd10, b1);
                check("lane1 accept spacing", 32'(b1 - a1), 32'd10);
            end
        join
        repeat (40) @(negedge clk);

        done0 = 1'b0;
        done1 = 1'b0;
        fork
            begin
                rand_lane(0, 30);
                done0 = 1'b1;
            end
            begin
                rand_lane(1, 60);
                done1 = 1'b1;
            end
            begin
                while (!(done0 && done1)) begin
                    @(negedge clk);
                    rsp_ready[0] = ($urandom_range(0, 3) != 0);
                    rsp_ready[1] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        repeat (50) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("lane%0d drained o_valid", l), {31'b0, obs_valid[l]}, 32'd0);
            check($sformatf("lane%0d drained o_ready", l), {31'b0, obs_ready[l]}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
